// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic and generator-polynomial construction
// for the systematic Reed-Solomon encoder.
package rs_pkg;

    localparam logic [8:0] GF_POLY  = 9'h11B;
    localparam logic [7:0] GF_ALPHA = 8'h03;
    localparam int         MAX_NSYM = 254;

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_e;

    typedef logic [8*MAX_NSYM-1:0] gpoly_t;

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0])
                     : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Coefficients g_0..g_{nsym-1} of the monic g(x), g_j in bits [8j+:8]
    function automatic gpoly_t gen_poly(
        input int nsym,
        input int fcr
    );
        logic [7:0] g [MAX_NSYM+1];
        logic [7:0] root;
        gpoly_t     r;
        for (int j = 0; j <= MAX_NSYM; j++) g[j] = 8'h00;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < fcr; i++) root = gf_mul(root, GF_ALPHA);
        for (int i = 0; i < nsym; i++) begin
            for (int j = i + 1; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul(g[j], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, GF_ALPHA);
        end
        r = '0;
        for (int j = 0; j < nsym; j++) r[8*j +: 8] = g[j];
        return r;
    endfunction

endpackage

// File: rtl/rs_encoder_gf256_cmul.sv
// Constant-coefficient GF(2^8) multiplier; folds to a fixed XOR network.
module gf256_cmul
    import rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder: passes K message bytes through, then shifts
// out NSYM parity bytes from the LFSR division register.
module rs_encoder
    import rs_pkg::*;
#(
    parameter int K    = 223,
    parameter int NSYM = 32,
    parameter int FCR  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last
);

    localparam int            CW     = $clog2(K > NSYM ? K : NSYM) + 1;
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] P_LAST = CW'(NSYM - 1);
    localparam gpoly_t        G      = gen_poly(NSYM, FCR);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    par_q [NSYM];
    logic [7:0]    par_d [NSYM];
    logic [7:0]    fb;
    logic [7:0]    fbg   [NSYM];
    logic          xfer;

    assign fb = s_data ^ par_q[NSYM-1];

    for (genvar i = 0; i < NSYM; i++) begin : g_mul
        gf256_cmul #(
            .COEF(G[8*i +: 8])
        ) u_mul (
            .a_i(fb),
            .p_o(fbg[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        xfer    = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = par_q[NSYM-1];
        m_last  = 1'b0;
        unique case (state_q)
            ST_DATA: begin
                s_ready = m_ready;
                m_valid = s_valid;
                m_data  = s_data;
                xfer    = s_valid & m_ready;
                if (xfer) begin
                    par_d[0] = fbg[0];
                    for (int i = 1; i < NSYM; i++) begin
                        par_d[i] = par_q[i-1] ^ fbg[i];
                    end
                    if (cnt_q == K_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                m_last = (cnt_q == P_LAST);
                xfer   = m_ready;
                if (xfer) begin
                    // Zero fill leaves the register clear for the next codeword
                    par_d[0] = 8'h00;
                    for (int i = 1; i < NSYM; i++) begin
                        par_d[i] = par_q[i-1];
                    end
                    if (cnt_q == P_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            for (int i = 0; i < NSYM; i++) par_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

endmodule
